mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/scpu_mem_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 33 +++
 rtl/mem_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/scpu_mem_pkg.sv
// scpu_mem_pkg: shared definitions for the CPU/loader memory bus.
//   - Default address and data widths for the bus.
//   - RAM/IO boundary. The arbiter passes addresses through unchanged;
//     the memory module uses this boundary for region decode.
//   - Arbiter FSM state encoding.
package scpu_mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  // Addresses at or above this value select IO; addresses below it select RAM.
  localparam logic [15:0] IO_BASE = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RD   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker with a last-served pointer.
//   clk, rst   clock and synchronous active-high reset
//   req_i      request levels {m1, m0}
//   take_i     the caller grants the pick this cycle if any request is high
//   valid_o    at least one request is high
//   sel_o      selected requester (0 = m0, 1 = m1)
// After reset the pointer reads "m1 served last", so m0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       valid_o,
  output logic       sel_o
);

  logic last_q, last_d;

  always_comb begin
    valid_o = |req_i;
    if (req_i == 2'b11) sel_o = ~last_q;
    else                sel_o = req_i[1];
    last_d = last_q;
    // The pointer moves only when a grant is actually issued.
    if (take_i && (|req_i)) last_d = sel_o;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the CPU (m0) and the
// loader/DMA (m1).
//   mX_req/we/addr/wdata   requester command; latched when the arbiter
//                          selects that requester
//   mX_gnt                 one-cycle pulse in the access cycle
//   mX_ack                 one-cycle pulse when the transaction completes
//   mX_rdata               last read result; held until the next read
//   mem_*                  memory strobes, address and data
// The memory is enabled only in ACC and RD. Address regions are decoded
// downstream, so addresses pass through unchanged.
//
// state | meaning
// IDLE  | sample requests, latch the winner's command
// ACC   | gnt pulse, chip enable, write or read strobe
// RD    | output enable, capture mem_rdata at the closing edge
// DONE  | ack pulse, all strobes low, then return to IDLE
module mem_bus_arbiter
  import scpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_ce,
  output logic              mem_w,
  output logic              mem_r,
  output logic              mem_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state_q, state_d;
  logic              sel_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
  logic              arb_valid, arb_sel, latch;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   ({m1_req, m0_req}),
    .take_i  (state_q == ST_IDLE),
    .valid_o (arb_valid),
    .sel_o   (arb_sel)
  );

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    m0_gnt  = 1'b0;
    m1_gnt  = 1'b0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    mem_ce  = 1'b0;
    mem_w   = 1'b0;
    mem_r   = 1'b0;
    mem_oe  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          latch   = 1'b1;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        m0_gnt  = ~sel_q;
        m1_gnt  = sel_q;
        mem_ce  = 1'b1;
        mem_w   = we_q;
        mem_r   = ~we_q;
        state_d = we_q ? ST_DONE : ST_RD;
      end
      ST_RD: begin
        mem_ce  = 1'b1;
        mem_oe  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        m0_ack  = ~sel_q;
        m1_ack  = sel_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        sel_q   <= arb_sel;
        we_q    <= arb_sel ? m1_we    : m0_we;
        addr_q  <= arb_sel ? m1_addr  : m0_addr;
        wdata_q <= arb_sel ? m1_wdata : m0_wdata;
      end
      if (state_q == ST_RD) begin
        if (sel_q) m1_rdata_q <= mem_rdata;
        else       m0_rdata_q <= mem_rdata;
      end
    end
  end

  // The address and data come from the latched command, so requester changes
  // after the latch edge do not reach the bus.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m1_addr;
  logic [7:0]  m0_wdata, m1_wdata;
  logic        m0_gnt, m0_ack, m1_gnt, m1_ack;
  logic [7:0]  m0_rdata, m1_rdata;
  logic        mem_ce, mem_w, mem_r, mem_oe;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  // Memory stand-in. It is written only through the DUT bus.
  bit [7:0] mem_arr [0:65535];
  assign mem_rdata = mem_arr[mem_addr];
  always @(posedge clk) if (mem_ce && mem_w) mem_arr[mem_addr] <= mem_wdata;

  // Reference model: the expected memory image, the expected read registers,
  // and the requester served last.
  bit [7:0]   ref_mem [0:65535];
  logic [7:0] ref_rd [2];
  int         last_m;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_ce(mem_ce), .mem_w(mem_w), .mem_r(mem_r), .mem_oe(mem_oe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bx(input bit g0, input bit g1, input bit a0, input bit a1,
                                    input bit ce, input bit mw, input bit mr, input bit oe);
    return {g0, g1, a0, a1, ce, mw, mr, oe};
  endfunction

  task automatic chk_bus(input string tag, input logic [7:0] exp);
    chk(tag, 32'({m0_gnt, m1_gnt, m0_ack, m1_ack, mem_ce, mem_w, mem_r, mem_oe}), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    last_m    = 1;
    ref_rd[0] = 8'h00;
    ref_rd[1] = 8'h00;
  endtask

  // One complete transaction, starting from an IDLE cycle. The winner is
  // predicted from the round-robin rule. In the grant cycle all requests are
  // dropped and the commands are scrambled; the bus must not follow them.
  task automatic run_txn(input logic [1:0] mask,
                         input logic we0, input logic [15:0] a0, input logic [7:0] d0,
                         input logic we1, input logic [15:0] a1, input logic [7:0] d1);
    int w;
    logic ew;
    logic [15:0] ea;
    logic [7:0] ed;
    m0_req = mask[0]; m0_we = we0; m0_addr = a0; m0_wdata = d0;
    m1_req = mask[1]; m1_we = we1; m1_addr = a1; m1_wdata = d1;
    if (mask == 2'b11) w = 1 - last_m;
    else               w = mask[1] ? 1 : 0;
    last_m = w;
    ew = (w == 1) ? we1 : we0;
    ea = (w == 1) ? a1 : a0;
    ed = (w == 1) ? d1 : d0;
    tick();
    chk_bus("acc_bus", bx(w == 0, w == 1, 0, 0, 1, ew, !ew, 0));
    chk("acc_addr", 32'(mem_addr), 32'(ea));
    chk("acc_wdata", 32'(mem_wdata), 32'(ed));
    m0_req = 1'b0; m1_req = 1'b0;
    m0_addr = m0_addr ^ 16'h0001; m1_addr = m1_addr ^ 16'h0001;
    m0_wdata = ~m0_wdata; m1_wdata = ~m1_wdata;
    m0_we = ~m0_we; m1_we = ~m1_we;
    if (!ew) begin
      tick();
      chk_bus("rd_bus", bx(0, 0, 0, 0, 1, 0, 0, 1));
      chk("rd_addr", 32'(mem_addr), 32'(ea));
    end else begin
      ref_mem[ea] = ed;
    end
    tick();
    if (!ew) ref_rd[w] = ref_mem[ea];
    chk_bus("done_bus", bx(0, 0, w == 0, w == 1, 0, 0, 0, 0));
    chk("m0_rdata", 32'(m0_rdata), 32'(ref_rd[0]));
    chk("m1_rdata", 32'(m1_rdata), 32'(ref_rd[1]));
    tick();
    chk_bus("idle_bus", 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  mask;
    logic [15:0] ra0, ra1;
    model_reset();
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    tick(); tick(); tick();
    chk_bus("reset_bus", 8'h00);
    chk("reset_m0_rdata", 32'(m0_rdata), 32'h0);
    chk("reset_m1_rdata", 32'(m1_rdata), 32'h0);
    chk("reset_addr", 32'(mem_addr), 32'h0);
    chk("reset_wdata", 32'(mem_wdata), 32'h0);
    rst = 1'b0;

    // Single write from m0, then a read of the same location from m1.
    run_txn(2'b01, 1, 16'h0010, 8'hA5, 0, 16'h0000, 8'h00);
    run_txn(2'b10, 0, 16'h0000, 8'h00, 0, 16'h0010, 8'h00);
    chk("read_a5", 32'(ref_rd[1]), 32'hA5);

    // IO address passes unchanged and reads back.
    run_txn(2'b01, 1, 16'h8000, 8'h3C, 0, 16'h0000, 8'h00);
    run_txn(2'b10, 0, 16'h0000, 8'h00, 0, 16'h8000, 8'h00);

    // Address changes from 0x0004 to 0x0005 in the grant cycle.
    run_txn(2'b01, 0, 16'h0004, 8'h00, 0, 16'h0000, 8'h00);

    // Both requests held across reset: alternation m0, m1, m0, ...
    rst = 1'b1;
    m0_req = 1; m0_we = 1; m0_addr = 16'h0100; m0_wdata = 8'h11;
    m1_req = 1; m1_we = 1; m1_addr = 16'h0200; m1_wdata = 8'h22;
    tick(); tick();
    chk("tie_reset_m1_rdata", 32'(m1_rdata), 32'h0);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_bus("tie_acc", bx(i % 2 == 0, i % 2 == 1, 0, 0, 1, 1, 0, 0));
      chk("tie_addr", 32'(mem_addr), (i % 2 == 0) ? 32'h0100 : 32'h0200);
      tick();
      chk_bus("tie_done", bx(0, 0, i % 2 == 0, i % 2 == 1, 0, 0, 0, 0));
      tick();
      chk_bus("tie_idle", 8'h00);
    end
    ref_mem[16'h0100] = 8'h11;
    ref_mem[16'h0200] = 8'h22;
    last_m = 1;
    m0_req = 0; m1_req = 0;

    // Reset during an m0 read: no ack, read registers cleared, m0 wins next tie.
    run_txn(2'b10, 0, 16'h0000, 8'h00, 0, 16'h0010, 8'h00);
    m0_req = 1; m0_we = 0; m0_addr = 16'h0200;
    tick();
    chk_bus("rst_acc", bx(1, 0, 0, 0, 1, 0, 1, 0));
    m0_req = 0;
    tick();
    chk_bus("rst_rd", bx(0, 0, 0, 0, 1, 0, 0, 1));
    rst = 1'b1;
    tick();
    chk_bus("rst_mid_bus", 8'h00);
    chk("rst_mid_m0_rdata", 32'(m0_rdata), 32'h0);
    chk("rst_mid_m1_rdata", 32'(m1_rdata), 32'h0);
    chk("rst_mid_addr", 32'(mem_addr), 32'h0);
    rst = 1'b0;
    model_reset();
    tick();
    chk_bus("rst_no_ack", 8'h00);
    run_txn(2'b11, 0, 16'h0100, 8'h00, 0, 16'h0200, 8'h00);
    chk("rst_tie_m0", 32'(m0_rdata), 32'h11);

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      mask = 2'($urandom_range(1, 3));
      ra0 = 16'($urandom_range(0, 7));
      ra1 = 16'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) ra0[15] = 1'b1;
      if ($urandom_range(0, 1) == 1) ra1[15] = 1'b1;
      run_txn(mask, 1'($urandom_range(0, 1)), ra0, 8'($urandom),
                    1'($urandom_range(0, 1)), ra1, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
